// File: rtl/turn_scheduler_pkg.sv
// Shared types and constants for the cat-vs-dog turn scheduler.
// Timing defaults are in 60 MHz clock cycles.
package turn_scheduler_pkg;

  localparam int TIMER_W = 30;
  localparam int HP_W    = 3;
  localparam int TURN_W  = 3;

  localparam int unsigned DEF_TURN_TIMEOUT_CYC = 600_000_000;  // 10 s
  localparam int unsigned DEF_FLIGHT_MAX_CYC   = 240_000_000;  // 4 s
  localparam int unsigned DEF_HP_INIT          = 3;
  localparam int unsigned DEF_HIT_DMG          = 1;

  localparam logic PLAYER_LOCAL  = 1'b0;
  localparam logic PLAYER_REMOTE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    THROW_START,
    IN_FLIGHT,
    RESOLVE,
    SWITCH,
    GAME_OVER
  } sched_state_t;

  // Hit points never go below zero, whatever the damage setting.
  function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp,
                                                   input logic [HP_W-1:0] dmg);
    return (hp > dmg) ? hp - dmg : '0;
  endfunction

endpackage

// File: rtl/turn_scheduler_cycle_timer.sv
// Shared cycle timer: counts while enabled, flags when the count equals the
// terminal value supplied by the caller.
module turn_scheduler_cycle_timer
  import turn_scheduler_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_en && (r_count == i_term);

endmodule

// File: rtl/turn_scheduler.sv
// Turn scheduler: grants the single projectile to the local or remote player,
// sequences flight and hit resolution, handles idle forfeits and declares a winner.
module turn_scheduler
  import turn_scheduler_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT_CYC = DEF_TURN_TIMEOUT_CYC,
  parameter int unsigned FLIGHT_MAX_CYC   = DEF_FLIGHT_MAX_CYC,
  parameter int unsigned HP_INIT          = DEF_HP_INIT,
  parameter int unsigned HIT_DMG          = DEF_HIT_DMG
) (
  input  logic              clk60MHz,
  input  logic              rst,
  input  logic              start,
  input  logic              local_req,
  input  logic              remote_req,
  input  logic              throw_done,
  input  logic              hit,
  output logic              grant_local,
  output logic              grant_remote,
  output logic              throw_start,
  output logic              throw_owner,
  output logic [TURN_W-1:0] turn,
  output logic [HP_W-1:0]   hp_local,
  output logic [HP_W-1:0]   hp_remote,
  output logic              game_over,
  output logic              winner,
  output logic [2:0]        state_dbg
);

  localparam logic [HP_W-1:0]    HP_RELOAD   = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0]    DMG         = HP_W'(HIT_DMG);
  localparam logic [TIMER_W-1:0] TURN_TERM   = TIMER_W'(TURN_TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] FLIGHT_TERM = TIMER_W'(FLIGHT_MAX_CYC - 1);

  sched_state_t      r_state;
  sched_state_t      w_state_next;
  logic              r_owner;
  logic [TURN_W-1:0] r_turn;
  logic [HP_W-1:0]   r_hp_local;
  logic [HP_W-1:0]   r_hp_remote;
  logic              r_winner;
  logic              r_hit_q;

  logic              w_owner_req;
  logic              w_start_game;
  logic              w_timer_en;
  logic              w_expired;
  logic [TIMER_W-1:0] w_term;
  logic [HP_W-1:0]   w_opp_hp;
  logic [HP_W-1:0]   w_opp_hp_next;

  assign w_owner_req   = (r_owner == PLAYER_LOCAL) ? local_req : remote_req;
  assign w_start_game  = start && ((r_state == IDLE) || (r_state == GAME_OVER));
  assign w_opp_hp      = (r_owner == PLAYER_LOCAL) ? r_hp_remote : r_hp_local;
  assign w_opp_hp_next = r_hit_q ? hp_after_hit(w_opp_hp, DMG) : w_opp_hp;

  // One timer serves both the idle-turn limit and the flight watchdog.
  assign w_timer_en = (r_state == WAIT_REQ) || (r_state == IN_FLIGHT);
  assign w_term     = (r_state == IN_FLIGHT) ? FLIGHT_TERM : TURN_TERM;

  turn_scheduler_cycle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk       (clk60MHz),
    .rst       (rst),
    .i_clr     (!w_timer_en),
    .i_en      (w_timer_en),
    .i_term    (w_term),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    grant_local  = 1'b0;
    grant_remote = 1'b0;
    throw_start  = 1'b0;
    game_over    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = WAIT_REQ;
      end
      WAIT_REQ: begin
        grant_local  = (r_owner == PLAYER_LOCAL);
        grant_remote = (r_owner == PLAYER_REMOTE);
        if (w_owner_req)    w_state_next = THROW_START;
        else if (w_expired) w_state_next = SWITCH;
      end
      THROW_START: begin
        throw_start  = 1'b1;
        w_state_next = IN_FLIGHT;
      end
      IN_FLIGHT: begin
        if (throw_done || w_expired) w_state_next = RESOLVE;
      end
      RESOLVE: begin
        w_state_next = (w_opp_hp_next == '0) ? GAME_OVER : SWITCH;
      end
      SWITCH: begin
        w_state_next = WAIT_REQ;
      end
      GAME_OVER: begin
        game_over = 1'b1;
        if (start) w_state_next = WAIT_REQ;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      r_owner     <= PLAYER_LOCAL;
      r_turn      <= TURN_W'(1);
      r_hp_local  <= HP_RELOAD;
      r_hp_remote <= HP_RELOAD;
      r_winner    <= PLAYER_LOCAL;
      r_hit_q     <= 1'b0;
    end else begin
      if (w_start_game) begin
        r_owner     <= PLAYER_LOCAL;
        r_turn      <= TURN_W'(1);
        r_hp_local  <= HP_RELOAD;
        r_hp_remote <= HP_RELOAD;
      end
      case (r_state)
        IN_FLIGHT: begin
          // A landing in the same cycle as the watchdog still counts.
          if (throw_done)     r_hit_q <= hit;
          else if (w_expired) r_hit_q <= 1'b0;
        end
        RESOLVE: begin
          if (r_owner == PLAYER_LOCAL) r_hp_remote <= w_opp_hp_next;
          else                         r_hp_local  <= w_opp_hp_next;
          if (w_opp_hp_next == '0)     r_winner    <= r_owner;
        end
        SWITCH: begin
          r_owner <= ~r_owner;
          r_turn  <= r_turn + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign throw_owner = r_owner;
  assign turn        = r_turn;
  assign hp_local    = r_hp_local;
  assign hp_remote   = r_hp_remote;
  assign winner      = r_winner;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: directed scenarios plus randomized
// games compared against a turn-level model of the game rules.
module tb_turn_scheduler;

  localparam int TO  = 100;
  localparam int FL  = 50;
  localparam int HP  = 3;
  localparam int DMG = 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_TSTART  = 3'd2;
  localparam logic [2:0] S_FLIGHT  = 3'd3;
  localparam logic [2:0] S_RESOLVE = 3'd4;
  localparam logic [2:0] S_SWITCH  = 3'd5;
  localparam logic [2:0] S_OVER    = 3'd6;

  localparam logic [17:0] RST_EXP = {4'b0000, 3'd1, 3'(HP), 3'(HP), 2'b00, S_IDLE};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic local_req = 1'b0;
  logic remote_req = 1'b0;
  logic throw_done = 1'b0;
  logic hit = 1'b0;
  logic grant_local, grant_remote, throw_start, throw_owner, game_over, winner;
  logic [2:0] turn, hp_local, hp_remote, state_dbg;

  int total = 0;
  int bad = 0;

  // Turn-level game model.
  int         m_hp_l, m_hp_r;
  logic [2:0] m_turn;
  logic       m_owner, m_over, m_winner;

  logic [11:0] dut_vec;
  logic [17:0] rst_vec;
  assign dut_vec = {hp_local, hp_remote, turn, throw_owner, game_over, game_over & winner};
  assign rst_vec = {grant_local, grant_remote, throw_start, throw_owner, turn,
                    hp_local, hp_remote, game_over, winner, state_dbg};

  turn_scheduler #(
    .TURN_TIMEOUT_CYC (TO),
    .FLIGHT_MAX_CYC   (FL),
    .HP_INIT          (HP),
    .HIT_DMG          (DMG)
  ) dut (
    .clk60MHz     (clk),
    .rst          (rst),
    .start        (start),
    .local_req    (local_req),
    .remote_req   (remote_req),
    .throw_done   (throw_done),
    .hit          (hit),
    .grant_local  (grant_local),
    .grant_remote (grant_remote),
    .throw_start  (throw_start),
    .throw_owner  (throw_owner),
    .turn         (turn),
    .hp_local     (hp_local),
    .hp_remote    (hp_remote),
    .game_over    (game_over),
    .winner       (winner),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] model_vec();
    return {3'(m_hp_l), 3'(m_hp_r), m_turn, m_owner, m_over, m_over & m_winner};
  endfunction

  task automatic m_new_game();
    m_hp_l = HP; m_hp_r = HP; m_turn = 3'd1; m_owner = 1'b0; m_over = 1'b0;
  endtask

  task automatic m_resolve(input logic h);
    int opp;
    opp = m_owner ? m_hp_l : m_hp_r;
    if (h) opp = (opp > DMG) ? opp - DMG : 0;
    if (m_owner) m_hp_l = opp; else m_hp_r = opp;
    if (opp == 0) begin
      m_over = 1'b1;
      m_winner = m_owner;
    end else begin
      m_owner = ~m_owner;
      m_turn = m_turn + 3'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
    m_new_game();
    m_winner = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_new_game();
  endtask

  // Owner request (optionally together with the other player); ends in THROW_START.
  task automatic launch(input logic both);
    if (m_owner) remote_req = 1'b1; else local_req = 1'b1;
    if (both) begin
      local_req = 1'b1;
      remote_req = 1'b1;
    end
    tick();
    local_req = 1'b0;
    remote_req = 1'b0;
  endtask

  // Called on the first IN_FLIGHT cycle; d >= FL lets the watchdog expire.
  task automatic fly(input int d, input logic h);
    if (d < FL) begin
      tick_n(d);
      throw_done = 1'b1;
      hit = h;
      tick();
      throw_done = 1'b0;
      hit = 1'b0;
      m_resolve(h);
    end else begin
      tick_n(FL);
      m_resolve(1'b0);
    end
    tick_n(2);
  endtask

  task automatic throw_turn(input logic both, input int d, input logic h);
    launch(both);
    tick();
    fly(d, h);
  endtask

  task automatic forfeit();
    tick_n(TO + 1);
    m_owner = ~m_owner;
    m_turn = m_turn + 3'd1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (rst_vec !== RST_EXP) begin
      bad++;
      $display("FAIL reset_values: got %h want %h", rst_vec, RST_EXP);
    end
    local_req = 1'b1;
    throw_done = 1'b1;
    tick();
    local_req = 1'b0;
    throw_done = 1'b0;
    tick_n(3);
    total++;
    if (rst_vec !== RST_EXP) begin
      bad++;
      $display("FAIL idle_ignores_inputs: got %h want %h", rst_vec, RST_EXP);
    end
  endtask

  task automatic test_launch();
    start_game();
    total++;
    if ({grant_local, grant_remote, state_dbg} !== {2'b10, S_WAIT}) begin
      bad++;
      $display("FAIL grant_before: got %b want %b", {grant_local, grant_remote, state_dbg}, {2'b10, S_WAIT});
    end
    tick_n($urandom_range(0, 20));
    launch(1'b0);
    total++;
    if ({throw_start, grant_local, throw_owner, state_dbg} !== {3'b100, S_TSTART}) begin
      bad++;
      $display("FAIL launch_pulse: got %b want %b", {throw_start, grant_local, throw_owner, state_dbg}, {3'b100, S_TSTART});
    end
    tick();
    total++;
    if ({throw_start, grant_local, state_dbg} !== {2'b00, S_FLIGHT}) begin
      bad++;
      $display("FAIL launch_single: got %b want %b", {throw_start, grant_local, state_dbg}, {2'b00, S_FLIGHT});
    end
    fly($urandom_range(0, 40), 1'b1);
    total++;
    if ({hp_remote, turn, throw_owner} !== {3'd2, 3'b010, 1'b1} || dut_vec !== model_vec()) begin
      bad++;
      $display("FAIL first_hit: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    start_game();
    remote_req = 1'b1;
    tick();
    remote_req = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({throw_start, grant_local, state_dbg} !== {2'b01, S_WAIT}) begin
      bad++;
      $display("FAIL non_owner_ignored: got %b want %b", {throw_start, grant_local, state_dbg}, {2'b01, S_WAIT});
    end
    tick_n(TO - 3);
    total++;
    if ({grant_local, state_dbg} !== {1'b1, S_WAIT}) begin
      bad++;
      $display("FAIL timeout_early: got %b want %b", {grant_local, state_dbg}, {1'b1, S_WAIT});
    end
    tick();
    total++;
    if ({grant_local, grant_remote, state_dbg} !== {2'b00, S_SWITCH}) begin
      bad++;
      $display("FAIL timeout_switch: got %b want %b", {grant_local, grant_remote, state_dbg}, {2'b00, S_SWITCH});
    end
    tick();
    m_owner = ~m_owner;
    m_turn = m_turn + 3'd1;
    total++;
    if (dut_vec !== model_vec() || grant_remote !== 1'b1) begin
      bad++;
      $display("FAIL forfeit_result: got %h/%b want %h/1", dut_vec, grant_remote, model_vec());
    end
    // Owner request on the expiry cycle beats the timeout.
    tick_n(TO - 1);
    remote_req = 1'b1;
    tick();
    remote_req = 1'b0;
    total++;
    if ({throw_start, throw_owner, state_dbg} !== {2'b11, S_TSTART}) begin
      bad++;
      $display("FAIL req_beats_timeout: got %b want %b", {throw_start, throw_owner, state_dbg}, {2'b11, S_TSTART});
    end
    tick();
    fly(FL, 1'b0);
    total++;
    if (dut_vec !== model_vec()) begin
      bad++;
      $display("FAIL late_throw_miss: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_both_reqs();
    if (!m_owner) forfeit();
    tick_n($urandom_range(0, 10));
    launch(1'b1);
    total++;
    if ({throw_start, throw_owner} !== 2'b11) begin
      bad++;
      $display("FAIL both_remote_launch: got %b want 11", {throw_start, throw_owner});
    end
    tick();
    total++;
    if ({throw_start, state_dbg} !== {1'b0, S_FLIGHT}) begin
      bad++;
      $display("FAIL both_single_pulse: got %b want %b", {throw_start, state_dbg}, {1'b0, S_FLIGHT});
    end
    fly($urandom_range(0, 45), 1'($urandom_range(0, 1)));
    total++;
    if (dut_vec !== model_vec()) begin
      bad++;
      $display("FAIL both_resolve: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    start_game();
    launch(1'b0);
    tick();
    tick_n(FL - 1);
    total++;
    if (state_dbg !== S_FLIGHT) begin
      bad++;
      $display("FAIL watchdog_early: got %0d want %0d", state_dbg, S_FLIGHT);
    end
    tick();
    total++;
    if (state_dbg !== S_RESOLVE) begin
      bad++;
      $display("FAIL watchdog_expire: got %0d want %0d", state_dbg, S_RESOLVE);
    end
    m_resolve(1'b0);
    tick_n(2);
    total++;
    if (dut_vec !== model_vec()) begin
      bad++;
      $display("FAIL watchdog_miss: got %h want %h", dut_vec, model_vec());
    end
    throw_turn(1'b0, FL - 1, 1'b1);
    total++;
    if (dut_vec !== model_vec() || hp_local !== 3'd2) begin
      bad++;
      $display("FAIL done_beats_watchdog: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_game_over();
    logic [11:0] frozen;
    do_reset();
    start_game();
    for (int i = 0; i < 3; i++) begin
      throw_turn(1'b0, $urandom_range(0, 45), 1'b1);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL local_hit_%0d: got %h want %h", i, dut_vec, model_vec());
      end
      if (!m_over) begin
        throw_turn(1'b0, ($urandom_range(0, 1) != 0) ? FL : $urandom_range(0, 45), 1'b0);
        total++;
        if (dut_vec !== model_vec()) begin
          bad++;
          $display("FAIL remote_miss_%0d: got %h want %h", i, dut_vec, model_vec());
        end
      end
    end
    total++;
    if ({game_over, winner, hp_remote, state_dbg} !== {2'b10, 3'd0, S_OVER}) begin
      bad++;
      $display("FAIL game_over: got %b want %b", {game_over, winner, hp_remote, state_dbg}, {2'b10, 3'd0, S_OVER});
    end
    frozen = model_vec();
    local_req = 1'b1;
    remote_req = 1'b1;
    tick();
    local_req = 1'b0;
    remote_req = 1'b0;
    total++;
    if ({throw_start, grant_local, grant_remote} !== 3'b000) begin
      bad++;
      $display("FAIL over_req_ignored: got %b want 000", {throw_start, grant_local, grant_remote});
    end
    throw_done = 1'b1;
    hit = 1'b1;
    tick();
    throw_done = 1'b0;
    hit = 1'b0;
    tick_n(3);
    total++;
    if (dut_vec !== frozen || state_dbg !== S_OVER) begin
      bad++;
      $display("FAIL over_frozen: got %h/%0d want %h/%0d", dut_vec, state_dbg, frozen, S_OVER);
    end
    start_game();
    total++;
    if ({hp_local, hp_remote, turn, throw_owner, game_over, grant_local, state_dbg} !==
        {3'(HP), 3'(HP), 3'd1, 2'b00, 1'b1, S_WAIT}) begin
      bad++;
      $display("FAIL restart: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 3; g++) begin
      do_reset();
      start_game();
      for (int n = 0; n < 60 && !m_over; n++) begin
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) begin
          forfeit();
        end else begin
          tick_n($urandom_range(0, 4));
          if (r == 2) begin
            if (m_owner) local_req = 1'b1; else remote_req = 1'b1;
            tick();
            local_req = 1'b0;
            remote_req = 1'b0;
          end
          throw_turn(r == 1, $urandom_range(0, FL + 5), 1'($urandom_range(0, 1)));
        end
        total++;
        if (dut_vec !== model_vec()) begin
          bad++;
          $display("FAIL random_g%0d_t%0d: got %h want %h", g, n, dut_vec, model_vec());
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    start_game();
    for (int i = 1; i <= 8; i++) begin
      forfeit();
      total++;
      if (turn !== m_turn || throw_owner !== m_owner) begin
        bad++;
        $display("FAIL wrap_%0d: got turn %b owner %b want turn %b owner %b", i, turn, throw_owner, m_turn, m_owner);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_game();
    throw_turn(1'b0, 0, 1'b1);
    launch(1'b0);
    tick_n(6);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (rst_vec !== RST_EXP) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", rst_vec, RST_EXP);
    end
    @(negedge clk);
    rst = 1'b0;
    tick_n(2);
    total++;
    if (rst_vec !== RST_EXP) begin
      bad++;
      $display("FAIL after_reset_idle: got %h want %h", rst_vec, RST_EXP);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_timeout();
    test_both_reqs();
    test_both_reqs();
    test_watchdog();
    test_game_over();
    test_random_games();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
Game-round controller for the cat-vs-dog throwing game. It grants the single throw/projectile resource to one player at a time: local (cat, mouse input) or remote (dog, UART link). It sequences each throw through flight and hit resolution, times out idle turns, tracks hit points and declares the winner. It sits between the input/UART decoders and the projectile engine, and drives the turn counter consumed by the display logic.

Parameters:
TURN_TIMEOUT_CYC, 600_000_000, cycles a granted player may idle before forfeiting the turn (10 s at 60 MHz); 30-bit counter.
FLIGHT_MAX_CYC, 240_000_000, watchdog on projectile flight; expiry is treated as a miss.
HP_INIT, 3, starting hit points per player; range 1..7.
HIT_DMG, 1, HP removed per hit; range 1..7.

Ports:
clk60MHz  in   1  system clock, 60 MHz
rst       in   1  asynchronous, active-high reset
start     in   1  one-cycle pulse; begins or restarts a game
local_req  in  1  one-cycle throw request from local player
remote_req in  1  one-cycle throw request from UART decoder
throw_done in  1  one-cycle pulse from projectile engine: flight ended
hit        in  1  qualifies throw_done; 1 = opponent hit
grant_local  out 1  local player may throw
grant_remote out 1  remote player may throw
throw_start  out 1  one-cycle pulse launching the projectile
throw_owner  out 1  0 = local, 1 = remote; current turn owner
turn       out  3  turn counter, increments per completed turn
hp_local   out  3  local HP
hp_remote  out  3  remote HP
game_over  out  1  level; high in GAME_OVER state
winner     out  1  0 = local, 1 = remote; valid while game_over
state_dbg  out  3  encoded FSM state

Behaviour:
- Reset (async, any state): state IDLE; grants 0; throw_start 0; throw_owner 0; turn 3'b001; hp_local = hp_remote = HP_INIT; game_over 0; winner 0; timers cleared. Reset mid-flight abandons the throw, and no pulse is emitted.
- All outputs are registered or decoded from the registered state. A request sampled at edge n produces throw_start high during cycle n+1.
- IDLE: start -> WAIT_REQ. Reload HP, turn = 3'b001, owner = local, timer cleared.
- WAIT_REQ: grant_<owner> = 1, the other grant = 0. The turn timer counts.
  - Request from owner -> THROW_START.
  - Request from non-owner is ignored.
  - Timer reaching TURN_TIMEOUT_CYC-1 -> SWITCH (forfeit, no damage).
  - Owner request in the same cycle as timeout: the request wins.
- THROW_START: one cycle. throw_start = 1, grants 0, timer cleared -> IN_FLIGHT.
- IN_FLIGHT: grants 0; the watchdog counts.
  - throw_done -> RESOLVE, with hit captured into hit_q.
  - Watchdog reaching FLIGHT_MAX_CYC-1 -> RESOLVE with hit_q = 0.
  - throw_done and watchdog expiry in the same cycle: throw_done wins.
- RESOLVE: one cycle.
  - If hit_q: opponent HP -= HIT_DMG, saturating at 0.
  - If the opponent's new HP is 0 -> GAME_OVER, winner = owner, turn not incremented.
  - Otherwise -> SWITCH.
- SWITCH: one cycle. Owner toggles; turn <= turn + 1 modulo 8 (3'b111 -> 3'b000); timer cleared -> WAIT_REQ.
- GAME_OVER: game_over = 1; grants 0; HP and winner frozen. start -> WAIT_REQ with the full IDLE reload.
- Ignored inputs:
  - start outside IDLE/GAME_OVER.
  - throw_done/hit outside IN_FLIGHT.
  - Requests outside WAIT_REQ.
- Both requests in the same cycle: only the owner's is honoured.
- Unreachable state encodings return to IDLE.

Decomposition:
- variable_pkg additions:
  - typedef enum logic [2:0] sched_state_t {IDLE, WAIT_REQ, THROW_START, IN_FLIGHT, RESOLVE, SWITCH, GAME_OVER}.
  - Constants PLAYER_LOCAL = 1'b0 and PLAYER_REMOTE = 1'b1.
  - Default timing constants, expressed in 60 MHz cycles.
- One sub-module, cycle_timer: 30-bit counter with clear/enable and a terminal-count compare input.
  - Instantiated once; the terminal value is muxed between TURN_TIMEOUT_CYC and FLIGHT_MAX_CYC by state.

Test Plan:
Bench params: TURN_TIMEOUT_CYC=100, FLIGHT_MAX_CYC=50, HP_INIT=3, HIT_DMG=1.
1. rst, then start; local_req at edge n -> throw_start pulse in cycle n+1 only; grant_local 1 before, 0 after; throw_done with hit=1 -> hp_remote 3->2, owner -> remote, turn 001->010.
2. In WAIT_REQ (owner local), pulse remote_req -> no throw_start; idle 100 cycles -> owner remote, turn increments, both HPs unchanged.
3. local_req and remote_req in the same cycle with owner remote -> exactly one throw_start, throw_owner = 1.
4. Launch, then no throw_done -> at 50 cycles RESOLVE as a miss: HP unchanged, owner toggles; throw_done coinciding with expiry and hit=1 -> HP decremented.
5. Three local hits interleaved with remote misses -> hp_remote = 0, game_over = 1, winner = 0, turn frozen; further reqs/throw_done ignored; start -> HP 3/3, turn 001, owner local.
6. Eight forfeited turns -> turn wraps 111->000. Assert rst during IN_FLIGHT -> all outputs at reset values asynchronously, before the next edge.
